// File: rtl/cross_bar_rr_if.sv
// Bus bundle for cross_bar_rr: producer-side write lanes and consumer-side output lanes.
// Write i is taken on a rising edge when wr_en[i] && !full[i]; output j transfers on an edge when valid[j] && !stall[j].
interface cross_bar_rr_if #(
    parameter int N_IN  = 8,
    parameter int N_OUT = 8,
    parameter int WIDTH = 8
);
    logic [N_IN-1:0]        wr_en;
    logic [N_IN*WIDTH-1:0]  d;
    logic [N_IN-1:0]        full;
    logic [N_IN-1:0]        almost_full;
    logic [N_OUT-1:0]       valid;
    logic [N_OUT*WIDTH-1:0] q;
    logic [N_OUT-1:0]       stall;

    modport slave (input wr_en, d, stall, output full, almost_full, valid, q);
    modport master (output wr_en, d, stall, input full, almost_full, valid, q);
endinterface

// File: rtl/cross_bar_rr.sv
// N_IN x N_OUT crossbar: per-input FWFT FIFOs, one round-robin arbiter per output, registered outputs with stall.
// Define CROSS_BAR_PERF_EN to add per-output grant counters (grant_cnt) with a synchronous clear (clr_cnt).
module cross_bar_rr #(
    parameter int N_IN      = 8,
    parameter int N_OUT     = 8,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef CROSS_BAR_PERF_EN
    input  logic                 clr_cnt,
    output logic [N_OUT*16-1:0]  grant_cnt,
`endif
    cross_bar_rr_if.slave        bus
);
    localparam int DW = $clog2(N_OUT);
    localparam int PW = $clog2(N_IN);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0]   mem [N_IN][DEPTH];
    logic [AW-1:0]      wr_ptr [N_IN];
    logic [AW-1:0]      rd_ptr [N_IN];
    logic [CW-1:0]      count [N_IN];
    logic [N_IN-1:0]    push, pop, empty, discard, full_w, af_w;
    logic [WIDTH-1:0]   head [N_IN];
    logic [DW-1:0]      head_dest [N_IN];
    logic [N_IN-1:0]    req [N_OUT];
    logic [PW-1:0]      ptr [N_OUT];
    logic [N_OUT-1:0]   load_ok, gnt_any, valid_r;
    logic [PW-1:0]      gnt_idx [N_OUT];
    logic [WIDTH-1:0]   q_r [N_OUT];
    logic [N_OUT*WIDTH-1:0] q_flat;

    // Flags come from the registered count only, so a same-cycle pop never admits a write into a full FIFO.
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            empty[i]     = (count[i] == '0);
            full_w[i]    = (count[i] == CW'(DEPTH));
            af_w[i]      = (count[i] >= CW'(DEPTH - AF_MARGIN));
            push[i]      = bus.wr_en[i] && !full_w[i];
            head[i]      = mem[i][rd_ptr[i]];
            head_dest[i] = head[i][WIDTH-1 -: DW];
            discard[i]   = !empty[i] && (int'(head_dest[i]) >= N_OUT);
        end
    end

    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            for (int i = 0; i < N_IN; i++) begin
                req[j][i] = !empty[i] && (int'(head_dest[i]) == j);
            end
        end
    end

    // Round-robin scan from ptr[j] upward; heads with an out-of-range destination are dropped here too.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = '0;
        pop     = discard;
        for (int j = 0; j < N_OUT; j++) begin
            gnt_idx[j] = '0;
            load_ok[j] = !valid_r[j] || !bus.stall[j];
            if (load_ok[j]) begin
                for (int k = 0; k < N_IN; k++) begin
                    idx = int'(ptr[j]) + k;
                    if (idx >= N_IN) idx = idx - N_IN;
                    if (!gnt_any[j] && req[j][idx]) begin
                        gnt_any[j] = 1'b1;
                        gnt_idx[j] = PW'(idx);
                    end
                end
            end
            if (gnt_any[j]) pop[gnt_idx[j]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_IN; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= bus.d[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
                count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                q_r[j] <= '0;
                ptr[j] <= '0;
            end
        end else begin
            for (int j = 0; j < N_OUT; j++) begin
                if (gnt_any[j]) begin
                    q_r[j]     <= head[gnt_idx[j]];
                    valid_r[j] <= 1'b1;
                    ptr[j]     <= (gnt_idx[j] == PW'(N_IN - 1)) ? '0 : gnt_idx[j] + PW'(1);
                end else if (load_ok[j]) begin
                    valid_r[j] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        q_flat = '0;
        for (int j = 0; j < N_OUT; j++) q_flat[j*WIDTH +: WIDTH] = q_r[j];
    end

    assign bus.full        = full_w;
    assign bus.almost_full = af_w;
    assign bus.valid       = valid_r;
    assign bus.q           = q_flat;

`ifdef CROSS_BAR_PERF_EN
    logic [15:0] cnt [N_OUT];

    // Clear takes priority over a grant in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < N_OUT; j++) cnt[j] <= '0;
        end else if (clr_cnt) begin
            for (int j = 0; j < N_OUT; j++) cnt[j] <= '0;
        end else begin
            for (int j = 0; j < N_OUT; j++) begin
                if (gnt_any[j]) cnt[j] <= cnt[j] + 16'd1;
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int j = 0; j < N_OUT; j++) grant_cnt[j*16 +: 16] = cnt[j];
    end
`endif
endmodule

// File: doc/cross_bar_rr.md
Name: cross_bar_rr

Overview:
Parametrised N_IN x N_OUT crossbar with per-input FWFT FIFOs, one round-robin arbiter per output and a registered output stage with per-output stall. Each input word carries its own destination in its top bits. It is the next generation of the fixed 8x8 crossbar and adds configurable port counts, width, FIFO depth, almost-full margin, fair arbitration and output backpressure. It sits between producer lanes and consumer lanes in the on-chip interconnect.

Parameters:
N_IN, 8, number of input ports (>=2)
N_OUT, 8, number of output ports (>=2)
WIDTH, 8, word width; must be > DW
DEPTH, 4, per-input FIFO depth, power of 2, >=2
AF_MARGIN, 1, almost_full asserts when count >= DEPTH-AF_MARGIN; 1 <= AF_MARGIN < DEPTH
(derived) DW = clog2(N_OUT), destination field width

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  N_IN  per-input write strobe
d  input  N_IN*WIDTH  input i word at d[i*WIDTH +: WIDTH]; destination = word[WIDTH-1 -: DW]
full  output  N_IN  input FIFO i full
almost_full  output  N_IN  input FIFO i at or above threshold
valid  output  N_OUT  output j holds a word
q  output  N_OUT*WIDTH  output j word at q[j*WIDTH +: WIDTH]; full word including destination bits
stall  input  N_OUT  consumer j not accepting

Behaviour:
- Reset (rst_n low, asynchronous): FIFOs empty; full=0; almost_full=0; valid=0; q=0; all RR pointers=0. Any in-flight words are discarded.
- Write: word accepted iff wr_en[i] && !full[i]. A write while full is ignored, with no corruption and no flag. full is derived from the registered count only, so a pop in the same cycle does not admit a write.
- Simultaneous push and pop on a non-full FIFO: the count is unchanged and ordering is preserved.
- FIFO head is FWFT (combinational). Head request to output j when the FIFO is non-empty and its destination equals j.
- Destination >= N_OUT (N_OUT not a power of 2): the head is popped and discarded in one cycle and never reaches any output.
- Output register j may load when !valid[j] || !stall[j].
- Arbitration for output j, when it may load:
  - Grant the first requester at or after ptr[j], scanning upward modulo N_IN.
  - Pop that FIFO, load q_j, set valid[j]=1.
  - Set ptr[j] = granted+1 mod N_IN.
- No requester and (!valid || !stall): valid[j]=0 next edge, q holds its last value, ptr unchanged.
- valid && stall: q and valid hold stable. No grant, ptr unchanged.
- valid && !stall: the word is consumed at that edge. A new word may load the same edge, giving full throughput of 1 word/cycle/output.
- Latency: a word written at edge t (empty path, no stall) is visible on q/valid after edge t+1.
- Each FIFO head targets one output, so at most one output pops a given FIFO per cycle.
- Reset asserted mid-operation clears everything per the first bullet. Deassertion is used synchronously via the existing reset synchroniser upstream.

Optional Feature:
CROSS_BAR_PERF_EN defined: adds output port grant_cnt (N_OUT*16), one counter per output at grant_cnt[j*16 +: 16].
- Increments on each word loaded into output j.
- Wraps 0xFFFF->0.
- Reset to 0.
- Adds port clr_cnt (1 bit), which synchronously zeroes all counters. If a grant occurs in the same cycle, clear wins.

Not defined: neither port exists and no counter logic is generated.

Test Plan:
- Reset mid-traffic: rst_n low between edges while valid=8'hFF -> valid=0, q=0, full=0 immediately, with no clock needed.
- Single word (defaults): wr_en[0]=1, d[7:0]=8'hA5 (dest 5) at edge t -> valid[5]=1 and q[47:40]=8'hA5 after edge t+1, for exactly one cycle; the other valid bits stay 0.
- Contention: inputs 0,3,6 each write one word to dest 2 on the same edge -> output 2 delivers input 0, then 3, then 6 on consecutive cycles and ptr[2]=7. A following write from inputs 0 and 7 to dest 2 delivers 7 then 0 (wrap).
- Backpressure: stall[2]=1, input 1 writes 6 words 8'h40..8'h45 (dest 2) on consecutive edges.
  - Output holds 8'h40.
  - almost_full[1]=1 at count 3; full[1]=1 at count 4.
  - 8'h45 is dropped.
  - After stall[2]=0, output 2 delivers 41,42,43,44 one per cycle and 45 never appears.
- Parallel: all 8 inputs write simultaneously, input i -> dest 7-i -> all 8 valid bits high after edge t+1, each q lane holding its input's word.
- CROSS_BAR_PERF_EN: 300 words to output 3 -> grant_cnt[63:48]=300. Pulsing clr_cnt -> 0 next edge.
